// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 port scheduler: command/response codes,
// port count, FSM state types and the command legality helper.
package calc1_pkg;

  localparam int NPORTS = 4;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_LSH = 4'd5;
  localparam logic [3:0] CMD_RSH = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_OP2,
    PORT_PEND
  } port_state_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  // True for the commands the ALU understands; anything else is answered
  // with an error by the scheduler itself.
  function automatic logic cmd_valid(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
           (cmd == CMD_LSH) || (cmd == CMD_RSH);
  endfunction

endpackage

// File: rtl/calc1_port_capture.sv
// Per-port request capture: takes command+operand1, then operand2, and holds
// the request pending until the scheduler returns its response.
module calc1_port_capture
  import calc1_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    cmd_in,
  input  logic [DW-1:0] data_in,
  input  logic          done,
  output logic          pend,
  output logic [3:0]    cmd,
  output logic [DW-1:0] op1,
  output logic [DW-1:0] op2
);

  port_state_e   state_q, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [DW-1:0] op1_q, op1_d;
  logic [DW-1:0] op2_q, op2_d;

  // Next-state logic; commands outside IDLE are dropped so the latched request stays intact
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    case (state_q)
      PORT_IDLE: begin
        if (cmd_in != CMD_NOP) begin
          cmd_d   = cmd_in;
          op1_d   = data_in;
          state_d = PORT_OP2;
        end
      end
      PORT_OP2: begin
        op2_d   = data_in;
        state_d = PORT_PEND;
      end
      PORT_PEND: begin
        if (done) begin
          state_d = PORT_IDLE;
        end
      end
      default: state_d = PORT_IDLE;
    endcase
  end

  // Capture registers, cleared on reset so any in-flight request is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PORT_IDLE;
      cmd_q   <= CMD_NOP;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
    end
  end

  assign pend = (state_q == PORT_PEND);
  assign cmd  = cmd_q;
  assign op1  = op1_q;
  assign op2  = op2_q;

endmodule

// File: rtl/calc1_port_scheduler.sv
// Shares one calc1 ALU between four requester ports: captures requests,
// grants the ALU round-robin and routes each result back to its port.
module calc1_port_scheduler
  import calc1_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          c_clk,
  input  logic          reset,
  input  logic [3:0]    req1_cmd_in,
  input  logic [3:0]    req2_cmd_in,
  input  logic [3:0]    req3_cmd_in,
  input  logic [3:0]    req4_cmd_in,
  input  logic [DW-1:0] req1_data_in,
  input  logic [DW-1:0] req2_data_in,
  input  logic [DW-1:0] req3_data_in,
  input  logic [DW-1:0] req4_data_in,
  output logic [1:0]    out1_resp,
  output logic [1:0]    out2_resp,
  output logic [1:0]    out3_resp,
  output logic [1:0]    out4_resp,
  output logic [DW-1:0] out1_data,
  output logic [DW-1:0] out2_data,
  output logic [DW-1:0] out3_data,
  output logic [DW-1:0] out4_data,
  output logic          alu_req,
  output logic [3:0]    alu_cmd,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  output logic [1:0]    alu_tag,
  input  logic          alu_done,
  input  logic [1:0]    alu_resp,
  input  logic [DW-1:0] alu_data
);

  logic [3:0]        req_cmd  [NPORTS];
  logic [DW-1:0]     req_data [NPORTS];
  logic [NPORTS-1:0] port_pend;
  logic [NPORTS-1:0] port_done;
  logic [3:0]        cap_cmd  [NPORTS];
  logic [DW-1:0]     cap_op1  [NPORTS];
  logic [DW-1:0]     cap_op2  [NPORTS];

  assign req_cmd[0]  = req1_cmd_in;
  assign req_cmd[1]  = req2_cmd_in;
  assign req_cmd[2]  = req3_cmd_in;
  assign req_cmd[3]  = req4_cmd_in;
  assign req_data[0] = req1_data_in;
  assign req_data[1] = req2_data_in;
  assign req_data[2] = req3_data_in;
  assign req_data[3] = req4_data_in;

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    calc1_port_capture #(.DW(DW)) u_capture (
      .clk     (c_clk),
      .rst_n   (reset),
      .cmd_in  (req_cmd[i]),
      .data_in (req_data[i]),
      .done    (port_done[i]),
      .pend    (port_pend[i]),
      .cmd     (cap_cmd[i]),
      .op1     (cap_op1[i]),
      .op2     (cap_op2[i])
    );
  end

  arb_state_e    arb_state_q, arb_state_d;
  logic [1:0]    last_grant_q, last_grant_d;
  logic          err_pend_q, err_pend_d;
  logic [1:0]    err_tag_q, err_tag_d;
  logic          alu_req_q, alu_req_d;
  logic [3:0]    alu_cmd_q, alu_cmd_d;
  logic [DW-1:0] alu_op1_q, alu_op1_d;
  logic [DW-1:0] alu_op2_q, alu_op2_d;
  logic [1:0]    alu_tag_q, alu_tag_d;
  logic [1:0]    out_resp_q [NPORTS];
  logic [1:0]    out_resp_d [NPORTS];
  logic [DW-1:0] out_data_q [NPORTS];
  logic [DW-1:0] out_data_d [NPORTS];

  logic          grant_valid;
  logic [1:0]    grant_idx;
  logic [1:0]    cand;

  // Round-robin search starting after the last granted port; a port whose error reply is queued is skipped
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_grant_q;
    cand        = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      cand = last_grant_q + 2'(k);
      if (!grant_valid && port_pend[cand] && !(err_pend_q && (err_tag_q == cand))) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Arbiter next state: issue valid commands, answer invalid ones locally, route ALU completions
  always_comb begin
    arb_state_d  = arb_state_q;
    last_grant_d = last_grant_q;
    err_pend_d   = 1'b0;
    err_tag_d    = err_tag_q;
    alu_req_d    = 1'b0;
    alu_cmd_d    = alu_cmd_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    alu_tag_d    = alu_tag_q;
    port_done    = '0;
    for (int i = 0; i < NPORTS; i++) begin
      out_resp_d[i] = RESP_NONE;
      out_data_d[i] = '0;
    end

    if (err_pend_q) begin
      out_resp_d[err_tag_q] = RESP_ERR;
      port_done[err_tag_q]  = 1'b1;
    end

    case (arb_state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          last_grant_d = grant_idx;
          if (cmd_valid(cap_cmd[grant_idx])) begin
            alu_req_d   = 1'b1;
            alu_cmd_d   = cap_cmd[grant_idx];
            alu_op1_d   = cap_op1[grant_idx];
            alu_op2_d   = cap_op2[grant_idx];
            alu_tag_d   = grant_idx;
            arb_state_d = ARB_BUSY;
          end else begin
            err_pend_d = 1'b1;
            err_tag_d  = grant_idx;
          end
        end
      end
      ARB_BUSY: begin
        if (alu_done) begin
          out_resp_d[alu_tag_q] = alu_resp;
          out_data_d[alu_tag_q] = alu_data;
          port_done[alu_tag_q]  = 1'b1;
          arb_state_d           = ARB_IDLE;
        end
      end
      default: arb_state_d = ARB_IDLE;
    endcase
  end

  // Arbiter and output registers; reset makes port 4 the last grant so port 1 wins first
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      arb_state_q  <= ARB_IDLE;
      last_grant_q <= 2'd3;
      err_pend_q   <= 1'b0;
      err_tag_q    <= '0;
      alu_req_q    <= 1'b0;
      alu_cmd_q    <= CMD_NOP;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_tag_q    <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        out_resp_q[i] <= RESP_NONE;
        out_data_q[i] <= '0;
      end
    end else begin
      arb_state_q  <= arb_state_d;
      last_grant_q <= last_grant_d;
      err_pend_q   <= err_pend_d;
      err_tag_q    <= err_tag_d;
      alu_req_q    <= alu_req_d;
      alu_cmd_q    <= alu_cmd_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      alu_tag_q    <= alu_tag_d;
      for (int i = 0; i < NPORTS; i++) begin
        out_resp_q[i] <= out_resp_d[i];
        out_data_q[i] <= out_data_d[i];
      end
    end
  end

  assign alu_req   = alu_req_q;
  assign alu_cmd   = alu_cmd_q;
  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;
  assign alu_tag   = alu_tag_q;
  assign out1_resp = out_resp_q[0];
  assign out2_resp = out_resp_q[1];
  assign out3_resp = out_resp_q[2];
  assign out4_resp = out_resp_q[3];
  assign out1_data = out_data_q[0];
  assign out2_data = out_data_q[1];
  assign out3_data = out_data_q[2];
  assign out4_data = out_data_q[3];

endmodule

// File: tb/tb_calc1_port_scheduler.sv
// Self-checking bench for calc1_port_scheduler: a behavioural ALU with
// programmable latency, a response scoreboard and a vector table.
module tb_calc1_port_scheduler;

  localparam int DW = 32;

  logic          c_clk = 1'b0;
  logic          reset;
  logic [3:0]    req_cmd  [4];
  logic [DW-1:0] req_data [4];
  logic [1:0]    out_resp [4];
  logic [DW-1:0] out_data [4];
  logic          alu_req;
  logic [3:0]    alu_cmd;
  logic [DW-1:0] alu_op1;
  logic [DW-1:0] alu_op2;
  logic [1:0]    alu_tag;
  logic          alu_done = 1'b0;
  logic [1:0]    alu_resp = 2'd0;
  logic [DW-1:0] alu_data = '0;

  always #5 c_clk = ~c_clk;

  calc1_port_scheduler #(.DW(DW)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (req_cmd[0]),
    .req2_cmd_in  (req_cmd[1]),
    .req3_cmd_in  (req_cmd[2]),
    .req4_cmd_in  (req_cmd[3]),
    .req1_data_in (req_data[0]),
    .req2_data_in (req_data[1]),
    .req3_data_in (req_data[2]),
    .req4_data_in (req_data[3]),
    .out1_resp    (out_resp[0]),
    .out2_resp    (out_resp[1]),
    .out3_resp    (out_resp[2]),
    .out4_resp    (out_resp[3]),
    .out1_data    (out_data[0]),
    .out2_data    (out_data[1]),
    .out3_data    (out_data[2]),
    .out4_data    (out_data[3]),
    .alu_req      (alu_req),
    .alu_cmd      (alu_cmd),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_tag      (alu_tag),
    .alu_done     (alu_done),
    .alu_resp     (alu_resp),
    .alu_data     (alu_data)
  );

  typedef struct {
    int          port;
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    bit          issues;
    logic [1:0]  expResp;
    logic [31:0] expData;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        expQ[$];
  int          tagLog[$];
  int          aluReqCount = 0;
  int          lastIssueCyc = -1;
  logic [3:0]  lastCmd = '0;
  logic [31:0] lastOp1 = '0;
  logic [31:0] lastOp2 = '0;
  int          aluLatency = 1;
  int          aluCnt = 0;
  logic [1:0]  aluPendResp = '0;
  logic [31:0] aluPendData = '0;
  logic [3:0]  vCmd [4];
  logic [31:0] vOp1 [4];
  logic [31:0] vOp2 [4];
  exp_t        monE;
  int          monN;
  vec_t        vecs [10];

  always @(posedge c_clk) cyc <= cyc + 1;

  // Compare one value, count it and report a failure line when it differs
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference ALU arithmetic: errors on carry/borrow, shift amount masked to 5 bits
  function automatic void aluModel(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   output logic [1:0] r, output logic [31:0] d);
    logic [32:0] s;
    r = 2'd2;
    d = '0;
    case (c)
      4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        if (!s[32]) begin r = 2'd1; d = s[31:0]; end
      end
      4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
      4'd5: begin r = 2'd1; d = a << b[4:0]; end
      4'd6: begin r = 2'd1; d = a >> b[4:0]; end
      default: begin r = 2'd2; d = '0; end
    endcase
  endfunction

  // Behavioural ALU: completes aluLatency cycles after each request, ignoring reset
  always @(negedge c_clk) begin
    alu_done = 1'b0;
    alu_resp = 2'd0;
    alu_data = '0;
    if (aluCnt > 0) begin
      aluCnt--;
      if (aluCnt == 0) begin
        alu_done = 1'b1;
        alu_resp = aluPendResp;
        alu_data = aluPendData;
      end
    end
    if (alu_req === 1'b1) begin
      aluModel(alu_cmd, alu_op1, alu_op2, aluPendResp, aluPendData);
      aluCnt = aluLatency;
    end
  end

  // Scoreboard: every response popped in order, plus a log of each ALU issue
  always @(negedge c_clk) begin
    if (reset === 1'b1) begin
      monN = 0;
      for (int p = 0; p < 4; p++) begin
        if (out_resp[p] != 2'd0) begin
          monN++;
          if (expQ.size() == 0) begin
            checkOutput("unexpected_resp", 32'(out_resp[p]), 32'd0);
          end else begin
            monE = expQ.pop_front();
            checkOutput("resp_port", 32'(p + 1), 32'(monE.port));
            checkOutput("resp_code", 32'(out_resp[p]), 32'(monE.resp));
            checkOutput("resp_data", out_data[p], monE.data);
            if (monE.cyc >= 0) checkOutput("resp_cycle", 32'(cyc), 32'(monE.cyc));
          end
        end
      end
      if (monN > 1) checkOutput("one_resp_per_cycle", 32'(monN), 32'd1);
      if (alu_req === 1'b1) begin
        aluReqCount++;
        tagLog.push_back(int'(alu_tag));
        lastIssueCyc = cyc;
        lastCmd = alu_cmd;
        lastOp1 = alu_op1;
        lastOp2 = alu_op2;
      end
    end
  end

  // Drive a two-cycle request on every port in mask; tCmd is the cycle of the command edge
  task automatic applyStimulus(input logic [3:0] mask, output int tCmd);
    @(negedge c_clk);
    tCmd = cyc + 1;
    for (int p = 0; p < 4; p++) if (mask[p]) begin req_cmd[p] = vCmd[p]; req_data[p] = vOp1[p]; end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) if (mask[p]) begin req_cmd[p] = 4'd0; req_data[p] = vOp2[p]; end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) if (mask[p]) req_data[p] = '0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge c_clk);
      n++;
    end
    checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
    repeat (2) @(negedge c_clk);
  endtask

  task automatic waitAluIdle(input int budget);
    int n = 0;
    while (aluCnt != 0 && n < budget) begin
      @(negedge c_clk);
      n++;
    end
    checkOutput("alu_idle_timeout", 32'(aluCnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int t2;
    int reqBefore;
    int tagStart;
    vec_t v;

    vecs[0] = '{1, 4'd1,  32'hFFFF0000, 32'h0000FFFF, 1'b1, 2'd1, 32'hFFFFFFFF};
    vecs[1] = '{2, 4'd2,  32'd10,       32'd3,        1'b1, 2'd1, 32'd7};
    vecs[2] = '{3, 4'd3,  32'd5,        32'd7,        1'b0, 2'd2, 32'd0};
    vecs[3] = '{4, 4'd5,  32'h1,        32'd4,        1'b1, 2'd1, 32'h10};
    vecs[4] = '{1, 4'd1,  32'hFFFFFFFF, 32'd1,        1'b1, 2'd2, 32'd0};
    vecs[5] = '{2, 4'd2,  32'd3,        32'd10,       1'b1, 2'd2, 32'd0};
    vecs[6] = '{3, 4'd6,  32'h80000000, 32'd31,       1'b1, 2'd1, 32'h1};
    vecs[7] = '{2, 4'd5,  32'h3,        32'd33,       1'b1, 2'd1, 32'h6};
    vecs[8] = '{1, 4'd7,  32'd1,        32'd2,        1'b0, 2'd2, 32'd0};
    vecs[9] = '{4, 4'd15, 32'd9,        32'd9,        1'b0, 2'd2, 32'd0};

    for (int p = 0; p < 4; p++) begin
      req_cmd[p] = 4'd0;
      req_data[p] = '0;
    end
    reset = 1'b0;
    repeat (3) @(negedge c_clk);
    checkOutput("reset_alu_req", 32'(alu_req), 32'd0);
    checkOutput("reset_alu_cmd", 32'(alu_cmd), 32'd0);
    checkOutput("reset_alu_op1", alu_op1, 32'd0);
    checkOutput("reset_alu_op2", alu_op2, 32'd0);
    checkOutput("reset_alu_tag", 32'(alu_tag), 32'd0);
    for (int p = 0; p < 4; p++) begin
      checkOutput("reset_out_resp", 32'(out_resp[p]), 32'd0);
      checkOutput("reset_out_data", out_data[p], 32'd0);
    end
    reset = 1'b1;
    repeat (2) @(negedge c_clk);

    $display("[TB] vector table, 1-cycle ALU");
    aluLatency = 1;
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      vCmd[v.port-1] = v.cmd;
      vOp1[v.port-1] = v.op1;
      vOp2[v.port-1] = v.op2;
      reqBefore = aluReqCount;
      applyStimulus(4'(1 << (v.port - 1)), t);
      expQ.push_back('{v.port, v.expResp, v.expData, v.issues ? t + 3 + aluLatency : t + 3});
      waitDrain(20);
      if (v.issues) begin
        checkOutput("issue_count", 32'(aluReqCount), 32'(reqBefore + 1));
        checkOutput("issue_cycle", 32'(lastIssueCyc), 32'(t + 2));
        checkOutput("issue_tag", 32'(tagLog[tagLog.size()-1]), 32'(v.port - 1));
        checkOutput("issue_cmd", 32'(lastCmd), 32'(v.cmd));
        checkOutput("issue_op1", lastOp1, v.op1);
        checkOutput("issue_op2", lastOp2, v.op2);
      end else begin
        checkOutput("invalid_no_issue", 32'(aluReqCount), 32'(reqBefore));
      end
    end

    $display("[TB] four-way contention, 3-cycle ALU");
    aluLatency = 3;
    for (int p = 0; p < 4; p++) begin
      vCmd[p] = 4'd1;
      vOp1[p] = 32'd1;
      vOp2[p] = 32'(p + 1);
    end
    tagStart = tagLog.size();
    applyStimulus(4'b1111, t);
    for (int p = 0; p < 4; p++) expQ.push_back('{p + 1, 2'd1, 32'(p + 2), -1});
    waitDrain(80);
    checkOutput("contention_issues", 32'(tagLog.size() - tagStart), 32'd4);
    if (tagLog.size() - tagStart == 4) begin
      for (int k = 0; k < 4; k++) checkOutput("contention_tag", 32'(tagLog[tagStart + k]), 32'(k));
    end
    vCmd[1] = 4'd1; vOp1[1] = 32'd40; vOp2[1] = 32'd2;
    applyStimulus(4'b0010, t);
    expQ.push_back('{2, 2'd1, 32'd42, t + 3 + aluLatency});
    waitDrain(30);
    checkOutput("follow_issue_cycle", 32'(lastIssueCyc), 32'(t + 2));
    checkOutput("follow_issue_tag", 32'(tagLog[tagLog.size()-1]), 32'd1);

    $display("[TB] overrun while pending");
    aluLatency = 4;
    vCmd[1] = 4'd2; vOp1[1] = 32'd10; vOp2[1] = 32'd3;
    reqBefore = aluReqCount;
    applyStimulus(4'b0010, t);
    expQ.push_back('{2, 2'd1, 32'd7, t + 3 + aluLatency});
    @(negedge c_clk); req_cmd[1] = 4'd1; req_data[1] = 32'd99;
    @(negedge c_clk); req_cmd[1] = 4'd0; req_data[1] = 32'd55;
    @(negedge c_clk); req_data[1] = '0;
    waitDrain(30);
    repeat (10) @(negedge c_clk);
    checkOutput("overrun_issue_count", 32'(aluReqCount), 32'(reqBefore + 1));
    checkOutput("overrun_op1", lastOp1, 32'd10);
    checkOutput("overrun_op2", lastOp2, 32'd3);

    $display("[TB] back-to-back reuse on port 4");
    aluLatency = 1;
    vCmd[3] = 4'd5; vOp1[3] = 32'h1; vOp2[3] = 32'd4;
    applyStimulus(4'b1000, t);
    expQ.push_back('{4, 2'd1, 32'h10, t + 4});
    @(negedge c_clk);
    @(negedge c_clk);
    vCmd[3] = 4'd6; vOp1[3] = 32'h80; vOp2[3] = 32'd3;
    applyStimulus(4'b1000, t2);
    checkOutput("reuse_cmd_cycle", 32'(t2), 32'(t + 5));
    expQ.push_back('{4, 2'd1, 32'h10, t2 + 4});
    waitDrain(30);

    $display("[TB] reset while ALU busy");
    aluLatency = 8;
    vCmd[0] = 4'd1; vOp1[0] = 32'd5; vOp2[0] = 32'd6;
    vCmd[2] = 4'd1; vOp1[2] = 32'd7; vOp2[2] = 32'd8;
    applyStimulus(4'b0101, t);
    @(negedge c_clk);
    @(negedge c_clk);
    reset = 1'b0;
    #1;
    checkOutput("midreset_alu_req", 32'(alu_req), 32'd0);
    checkOutput("midreset_alu_cmd", 32'(alu_cmd), 32'd0);
    checkOutput("midreset_alu_op1", alu_op1, 32'd0);
    checkOutput("midreset_alu_op2", alu_op2, 32'd0);
    for (int p = 0; p < 4; p++) begin
      checkOutput("midreset_out_resp", 32'(out_resp[p]), 32'd0);
      checkOutput("midreset_out_data", out_data[p], 32'd0);
    end
    @(negedge c_clk);
    reset = 1'b1;
    reqBefore = aluReqCount;
    waitAluIdle(40);
    repeat (4) @(negedge c_clk);
    checkOutput("postreset_no_issue", 32'(aluReqCount), 32'(reqBefore));

    aluLatency = 1;
    vCmd[0] = 4'd1; vOp1[0] = 32'd20; vOp2[0] = 32'd1;
    vCmd[1] = 4'd1; vOp1[1] = 32'd30; vOp2[1] = 32'd2;
    tagStart = tagLog.size();
    applyStimulus(4'b0011, t);
    expQ.push_back('{1, 2'd1, 32'd21, t + 4});
    expQ.push_back('{2, 2'd1, 32'd32, -1});
    waitDrain(30);
    checkOutput("postreset_issues", 32'(tagLog.size() - tagStart), 32'd2);
    if (tagLog.size() - tagStart == 2) begin
      checkOutput("postreset_first_tag", 32'(tagLog[tagStart]), 32'd0);
      checkOutput("postreset_second_tag", 32'(tagLog[tagStart + 1]), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc1_port_scheduler.md
# calc1_port_scheduler

Front-end scheduler that shares one calc1 ALU between the four calc1 requester ports. Each port speaks the calc1 two-cycle request protocol (command + operand1, then operand2). The block captures each request, grants the ALU round-robin, and returns a one-cycle response on the originating port. It sits between the port drivers and the shared ALU datapath, with one ALU operation in flight at a time.

## Interface
- `NPORTS`, default 4: requester ports. This is fixed at 4; ports are named 1..4.
- `DW`, default 32: operand and result width.
- `c_clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `reqN_cmd_in` in 4 (N=1..4): port N command. Valid values are NOP=0, ADD=1, SUB=2, LSH=5, RSH=6.
- `reqN_data_in` in DW (N=1..4): operand1 in the command cycle, operand2 in the following cycle.
- `outN_resp` out 2 (N=1..4): 0=none, 1=success, 2=error (overflow, underflow or invalid command).
- `outN_data` out DW (N=1..4): result. Valid only while `outN_resp`≠0.
- `alu_req` out 1: one-cycle issue strobe to the ALU.
- `alu_cmd` out 4: command for the ALU.
- `alu_op1` out DW: operand1 for the ALU.
- `alu_op2` out DW: operand2 for the ALU.
- `alu_tag` out 2: index (port−1) of the port being issued.
- `alu_done` in 1: one-cycle completion pulse from the ALU, sent any number of cycles (≥1) after `alu_req`.
- `alu_resp` in 2: ALU status (1 or 2). Sampled with `alu_done`.
- `alu_data` in DW: ALU result. Sampled with `alu_done`.

## Operation
- **Per-port capture FSM**, states IDLE, OP2, PEND:
  - IDLE: on `cmd≠0`, latch cmd and op1, then go to OP2.
  - OP2: latch op2 unconditionally, then go to PEND.
  - PEND: hold until this port's response is emitted, then go to IDLE.
- **Commands while not IDLE** (`cmd≠0` in OP2 or PEND) are ignored. They produce no response and must not corrupt the latched request.
- **Arbiter FSM**, states IDLE, BUSY:
  - In IDLE, if any port is in PEND and not already granted, grant the first pending port searching from `last_grant+1` (wrapping 4→1).
  - If the granted cmd is valid: assert `alu_req` with the captured fields, record `last_grant`, and go to BUSY.
  - If the granted cmd is invalid (3, 4, 7–15): do not issue to the ALU. Emit resp=2, data=0 on that port next cycle, update `last_grant`, and stay in IDLE.
  - In BUSY, on `alu_done`, register `alu_resp`/`alu_data` to the port selected by the stored tag, then go to IDLE.
- **Response emission:** a port's response is asserted for exactly one cycle. The port returns to IDLE in that same cycle and may accept a new command in the next cycle.
- The block does no arithmetic. `alu_op1`/`alu_op2` pass the full DW bits, and the ALU applies shift-amount masking.
- **Reset values:**
  - All `outN_resp`=0 and `outN_data`=0.
  - `alu_req`=0; `alu_cmd`, `alu_op1`, `alu_op2`, `alu_tag`=0.
  - Every port FSM is in IDLE; the arbiter is in IDLE.
  - `last_grant`=port 4, so port 1 wins first.
- **Reset mid-operation:** all captured requests are discarded. A late `alu_done` arriving after reset deassertion while the arbiter is in IDLE is ignored.
- **`alu_done` while in IDLE** is always ignored.

## Timing
- **Request cycles:** command at edge T, operand2 captured at T+1, port enters PEND at T+2.
- **Issue:** with the arbiter idle and no contention, `alu_req` is high in cycle T+2, registered.
- **Response:**
  - `outN_resp` is high in the cycle after `alu_done`.
  - With a 1-cycle ALU (`alu_done` at T+3), the response appears at T+4.
  - For an invalid command, the response appears at T+3.
- **Issue rate:** at most one `alu_req` per ALU round trip. At most one response per cycle across all ports.
- **Simultaneous PEND on several ports:** grant strictly round-robin. Each waiting port is served within 4 ALU operations.
- **New command on the response cycle:** a port may present a new command in the same cycle its response is emitted, since it is back in IDLE. That command is accepted, not ignored.

## Structure
- **Shared package `calc1_pkg`:**
  - CMD_NOP, CMD_ADD, CMD_SUB, CMD_LSH, CMD_RSH.
  - RESP_NONE, RESP_OK, RESP_ERR.
  - NPORTS.
  - A `cmd_valid()` function.
- **Sub-module `calc1_port_capture`:** the IDLE/OP2/PEND FSM plus the cmd/op1/op2 registers, instanced ×4.
- The round-robin arbiter and response routing live in the top module.

## Test plan
1. **Single add:** port 1 sends ADD with 0xFFFF0000, then 0x0000FFFF; the model ALU has 1-cycle latency. Required: `alu_req` at T+2 carrying those operands, then `out1_resp`=1 and `out1_data`=0xFFFFFFFF at T+4, for one cycle only.
2. **Four-way contention:** all four ports send ADD 1+N in the same cycle; the ALU has 3-cycle latency. Required: `alu_tag` sequence 0,1,2,3 and responses in port order 1,2,3,4 with data 2,3,4,5. A following round led by port 2 only is granted immediately.
3. **Invalid command:** port 3 sends cmd=3 with 5, then 7. Required: no `alu_req` is issued, and `out3_resp`=2 with `out3_data`=0 at T+3.
4. **Overrun:** port 2 sends SUB 10−3, then sends ADD while in PEND. Required: exactly one response, resp=1 and data=7; the second command is dropped.
5. **Reset during BUSY:** assert `reset`=0 while an ALU operation is in flight. Required: all outputs are 0 immediately. The ALU's `alu_done` arriving after release is ignored, no `outN_resp` fires, and port 1 is granted first afterwards.
6. **Back-to-back reuse:** port 4 issues LSH 0x1 by 4; on its response cycle, it presents RSH 0x80 by 3. Required: responses 0x10, then 0x10.
